projectile_pool: RTL and testbench

Parametrised successor to the single-ball entity logic: a pool of N_SLOTS independent projectiles (allied or enemy bullets) sharing one clock domain.
- Accepts spawn requests and advances every live projectile once per frame tick.
- Frees projectiles that leave the screen or hit a target rectangle, and reports hits.
- Drives a registered per-pixel "projectile here" flag for the screen compositor.

---
 rtl/projectile_pool_pkg.sv | 24 ++
 rtl/projectile_pool_if.sv | 28 ++
 rtl/projectile_pool_free_encoder.sv | 20 ++
 rtl/projectile_pool.sv | 211 +++++++++++++++++++++
 tb/tb_projectile_pool.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/projectile_pool_pkg.sv
// Shared types for the projectile pool: scan FSM states, slot record and a
// distance helper used by the pixel compositor path.
package projectile_pool_pkg;

  localparam int COORD_W_DEF = 10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } slot_t;

  // Absolute difference without ever forming a negative intermediate.
  function automatic logic [COORD_W_DEF-1:0] abs_diff(input logic [COORD_W_DEF-1:0] a,
                                                      input logic [COORD_W_DEF-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// Spawn request channel between the game logic (master) and the pool (slave).
interface projectile_pool_if
  import projectile_pool_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);

  // spawn_req is a level held by the master, with spawn_x/spawn_y stable, until
  // exactly one of spawn_ack / spawn_drop pulses for a single cycle. The pool
  // never evaluates a request during that pulse cycle, so a request still held
  // afterwards is treated as a fresh one.
  logic               spawn_req;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic               spawn_ack;
  logic               spawn_drop;

  modport master (
    output spawn_req, spawn_x, spawn_y,
    input  spawn_ack, spawn_drop
  );

  modport slave (
    input  spawn_req, spawn_x, spawn_y,
    output spawn_ack, spawn_drop
  );

endinterface

// File: rtl/projectile_pool_free_encoder.sv
// Lowest-index free slot finder: any_free is set when at least one slot is
// not valid, and index names the lowest such slot.
module pool_free_encoder #(
  parameter  int N_SLOTS = 8,
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0] valid,
  output logic               any_free,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    any_free = ~&valid;
    index    = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// Pool of projectile slots: allocates on spawn, moves every live slot once per
// frame tick (one slot per cycle), frees on leaving the screen or hitting the target.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter  int N_SLOTS  = 8,
  parameter  int COORD_W  = COORD_W_DEF,
  parameter  int SPEED    = 4,
  parameter  int RAIO     = 3,
  parameter  int SCREEN_H = 480,
  parameter  bit DIR_DOWN = 1'b0,
  localparam int IDX_W    = $clog2(N_SLOTS),
  localparam int CNT_W    = $clog2(N_SLOTS + 1)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                pausa,
  input  logic                tick,
  projectile_pool_if.slave    spawn,
  input  logic [COORD_W-1:0]  alvo_x,
  input  logic [COORD_W-1:0]  alvo_y,
  input  logic [COORD_W-1:0]  alvo_largura,
  input  logic [COORD_W-1:0]  alvo_altura,
  output logic                hit,
  output logic [7:0]          hit_count,
  output logic [CNT_W-1:0]    ativos,
  output logic                overrun,
  input  logic [COORD_W-1:0]  VGA_X,
  input  logic [COORD_W-1:0]  VGA_Y,
  output logic                pixel_on,
  output state_t              state_dbg,
  output logic [IDX_W-1:0]    idx_dbg,
  output slot_t [N_SLOTS-1:0] slots_dbg
);

  localparam logic [COORD_W:0]   SPEED_W    = (COORD_W + 1)'(SPEED);
  localparam logic [COORD_W:0]   SCREEN_H_W = (COORD_W + 1)'(SCREEN_H);
  localparam logic [COORD_W-1:0] RAIO_C     = COORD_W'(RAIO);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_SLOTS - 1);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 pending_q, pending_n;
  logic                 overrun_n;
  slot_t [N_SLOTS-1:0]  slots_q, slots_n;
  logic                 hit_n;
  logic [7:0]           hit_count_n;
  logic                 ack_q, ack_n;
  logic                 drop_q, drop_n;
  logic [CNT_W-1:0]     ativos_n;
  logic                 pix_any;

  logic [N_SLOTS-1:0]   valid_vec;
  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;

  logic                 tick_acc;
  logic                 spawn_go;
  slot_t                cur;
  logic [COORD_W:0]     y_ext;
  logic [COORD_W:0]     y_sum;
  logic [COORD_W-1:0]   new_y;
  logic                 off_screen;
  logic                 in_target;

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) valid_vec[i] = slots_q[i].valid;
  end

  pool_free_encoder #(.N_SLOTS(N_SLOTS)) u_free_enc (
    .valid    (valid_vec),
    .any_free (any_free),
    .index    (free_idx)
  );

  // A tick in the same cycle wins over a spawn; the held request simply waits.
  assign tick_acc = tick & ~pausa;
  assign spawn_go = (state_q == IDLE) & ~pausa & ~tick & spawn.spawn_req & ~ack_q & ~drop_q;

  assign cur   = slots_q[idx_q];
  assign y_ext = {1'b0, cur.y};

  always_comb begin
    if (DIR_DOWN) begin
      y_sum      = y_ext + SPEED_W;
      off_screen = (y_sum >= SCREEN_H_W);
    end else begin
      y_sum      = y_ext - SPEED_W;
      off_screen = (y_ext < SPEED_W);
    end
    new_y = y_sum[COORD_W-1:0];
  end

  // Half-open rectangle test on the moved position; bounds widened by one bit.
  assign in_target = ({1'b0, alvo_x} <= {1'b0, cur.x}) &&
                     ({1'b0, cur.x}  <  ({1'b0, alvo_x} + {1'b0, alvo_largura})) &&
                     ({1'b0, alvo_y} <= {1'b0, new_y}) &&
                     ({1'b0, new_y}  <  ({1'b0, alvo_y} + {1'b0, alvo_altura}));

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    pending_n   = pending_q;
    overrun_n   = overrun;
    slots_n     = slots_q;
    hit_n       = 1'b0;
    hit_count_n = hit_count;
    ack_n       = 1'b0;
    drop_n      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_acc) begin
          state_n = UPDATE;
          idx_n   = '0;
        end else if (spawn_go) begin
          if (any_free) begin
            slots_n[free_idx].valid = 1'b1;
            slots_n[free_idx].x     = spawn.spawn_x;
            slots_n[free_idx].y     = spawn.spawn_y;
            ack_n                   = 1'b1;
          end else begin
            drop_n = 1'b1;
          end
        end
      end
      UPDATE: begin
        if (tick_acc) begin
          if (pending_q) overrun_n = 1'b1;
          else           pending_n = 1'b1;
        end
        if (cur.valid) begin
          if (off_screen) begin
            slots_n[idx_q].valid = 1'b0;
          end else if (in_target) begin
            slots_n[idx_q].valid = 1'b0;
            hit_n                = 1'b1;
            hit_count_n          = hit_count + 8'd1;
          end else begin
            slots_n[idx_q].y = new_y;
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_n = '0;
          if (pending_n) begin
            pending_n = 1'b0;
            state_n   = UPDATE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ativos_n = '0;
    for (int i = 0; i < N_SLOTS; i++) ativos_n = ativos_n + CNT_W'(slots_n[i].valid);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun   <= 1'b0;
      slots_q   <= '0;
      hit       <= 1'b0;
      hit_count <= '0;
      ack_q     <= 1'b0;
      drop_q    <= 1'b0;
      ativos    <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      pending_q <= pending_n;
      overrun   <= overrun_n;
      slots_q   <= slots_n;
      hit       <= hit_n;
      hit_count <= hit_count_n;
      ack_q     <= ack_n;
      drop_q    <= drop_n;
      ativos    <= ativos_n;
    end
  end

  // Compositor path looks at the slots as registered, giving a fixed one-cycle latency.
  always_comb begin
    pix_any = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slots_q[i].valid &&
          (abs_diff(VGA_X, slots_q[i].x) <= RAIO_C) &&
          (abs_diff(VGA_Y, slots_q[i].y) <= RAIO_C))
        pix_any = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) pixel_on <= 1'b0;
    else       pixel_on <= pix_any;
  end

  assign spawn.spawn_ack  = ack_q;
  assign spawn.spawn_drop = drop_q;
  assign state_dbg        = state_q;
  assign idx_dbg          = idx_q;
  assign slots_dbg        = slots_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: an upward-moving pool and a downward-moving pool
// checked against an array model of slots, targets and pixel coverage.
module tb_projectile_pool;
  import projectile_pool_pkg::*;

  localparam int N     = 8;
  localparam int CW    = 10;
  localparam int SPEED = 4;
  localparam int RAIO  = 3;
  localparam int SH    = 480;

  typedef slot_t [N-1:0] slot_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, pausa, tick, b_tick;
  logic [CW-1:0] alvo_x, alvo_y, alvo_w, alvo_h, vga_x, vga_y;
  logic [CW-1:0] b_zero;
  assign b_zero = '0;

  logic       a_hit, a_overrun, a_pixel_on;
  logic [7:0] a_hit_count;
  logic [3:0] a_ativos;
  state_t     a_state;
  logic [2:0] a_idx;
  slot_vec_t  a_slots;

  logic       b_hit, b_overrun, b_pixel_on;
  logic [7:0] b_hit_count;
  logic [3:0] b_ativos;
  state_t     b_state;
  logic [2:0] b_idx;
  slot_vec_t  b_slots;

  projectile_pool_if #(.COORD_W(CW)) a_if ();
  projectile_pool_if #(.COORD_W(CW)) b_if ();

  projectile_pool #(.N_SLOTS(N), .COORD_W(CW), .SPEED(SPEED), .RAIO(RAIO),
                    .SCREEN_H(SH), .DIR_DOWN(1'b0)) dut_a (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .tick(tick), .spawn(a_if),
    .alvo_x(alvo_x), .alvo_y(alvo_y), .alvo_largura(alvo_w), .alvo_altura(alvo_h),
    .hit(a_hit), .hit_count(a_hit_count), .ativos(a_ativos), .overrun(a_overrun),
    .VGA_X(vga_x), .VGA_Y(vga_y), .pixel_on(a_pixel_on),
    .state_dbg(a_state), .idx_dbg(a_idx), .slots_dbg(a_slots)
  );

  projectile_pool #(.N_SLOTS(N), .COORD_W(CW), .SPEED(SPEED), .RAIO(RAIO),
                    .SCREEN_H(SH), .DIR_DOWN(1'b1)) dut_b (
    .CLOCK_50(clk), .reset(reset), .pausa(1'b0), .tick(b_tick), .spawn(b_if),
    .alvo_x(b_zero), .alvo_y(b_zero), .alvo_largura(b_zero), .alvo_altura(b_zero),
    .hit(b_hit), .hit_count(b_hit_count), .ativos(b_ativos), .overrun(b_overrun),
    .VGA_X(vga_x), .VGA_Y(vga_y), .pixel_on(b_pixel_on),
    .state_dbg(b_state), .idx_dbg(b_idx), .slots_dbg(b_slots)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = upward pool, 1 = downward pool.
  int m_valid [2][N];
  int m_x     [2][N];
  int m_y     [2][N];
  int m_hits  [2];
  int t_ax, t_ay, t_aw, t_ah;

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      m_hits[d] = 0;
      for (int i = 0; i < N; i++) begin
        m_valid[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0;
      end
    end
  endfunction

  function automatic int model_spawn(int d, int x, int y);
    for (int i = 0; i < N; i++) begin
      if (m_valid[d][i] == 0) begin
        m_valid[d][i] = 1; m_x[d][i] = x; m_y[d][i] = y;
        return i;
      end
    end
    return -1;
  endfunction

  function automatic void model_tick(int d, int ax, int ay, int aw, int ah);
    int ny;
    for (int i = 0; i < N; i++) begin
      if (m_valid[d][i] != 0) begin
        ny = (d == 1) ? m_y[d][i] + SPEED : m_y[d][i] - SPEED;
        if ((d == 0 && ny < 0) || (d == 1 && ny >= SH)) begin
          m_valid[d][i] = 0;
        end else if (ax <= m_x[d][i] && m_x[d][i] < ax + aw && ay <= ny && ny < ay + ah) begin
          m_valid[d][i] = 0;
          m_hits[d]++;
        end else begin
          m_y[d][i] = ny;
        end
      end
    end
  endfunction

  function automatic int model_count(int d);
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[d][i];
    return c;
  endfunction

  function automatic slot_vec_t model_slots(int d);
    slot_vec_t v = '0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[d][i] != 0) begin
        v[i].valid = 1'b1; v[i].x = CW'(m_x[d][i]); v[i].y = CW'(m_y[d][i]);
      end
    end
    return v;
  endfunction

  function automatic slot_vec_t live_only(slot_vec_t s);
    slot_vec_t v = '0;
    for (int i = 0; i < N; i++) if (s[i].valid) v[i] = s[i];
    return v;
  endfunction

  function automatic logic model_pixel(int vx, int vy);
    int dx, dy;
    for (int i = 0; i < N; i++) begin
      dx = (vx > m_x[0][i]) ? vx - m_x[0][i] : m_x[0][i] - vx;
      dy = (vy > m_y[0][i]) ? vy - m_y[0][i] : m_y[0][i] - vy;
      if (m_valid[0][i] != 0 && dx <= RAIO && dy <= RAIO) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- driver tasks (enter and leave just after a rising edge) ----
  task automatic set_target(input int ax, input int ay, input int aw, input int ah);
    t_ax = ax; t_ay = ay; t_aw = aw; t_ah = ah;
    alvo_x = CW'(ax); alvo_y = CW'(ay); alvo_w = CW'(aw); alvo_h = CW'(ah);
  endtask

  task automatic do_reset();
    reset = 1'b1; pausa = 1'b0; tick = 1'b0; b_tick = 1'b0;
    a_if.spawn_req = 1'b0; a_if.spawn_x = '0; a_if.spawn_y = '0;
    b_if.spawn_req = 1'b0; b_if.spawn_x = '0; b_if.spawn_y = '0;
    vga_x = '0; vga_y = '0;
    set_target(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic do_spawn(input int d, input int x, input int y, output logic ack, output logic drop);
    if (d == 1) begin b_if.spawn_x = CW'(x); b_if.spawn_y = CW'(y); b_if.spawn_req = 1'b1; end
    else        begin a_if.spawn_x = CW'(x); a_if.spawn_y = CW'(y); a_if.spawn_req = 1'b1; end
    ack = 1'b0; drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ack  = (d == 1) ? b_if.spawn_ack  : a_if.spawn_ack;
      drop = (d == 1) ? b_if.spawn_drop : a_if.spawn_drop;
      if (ack || drop) break;
    end
    @(posedge clk); #1;
    a_if.spawn_req = 1'b0; b_if.spawn_req = 1'b0;
  endtask

  task automatic wait_idle(input int d, output int hits_seen, output logic timed_out);
    hits_seen = 0; timed_out = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      hits_seen += (d == 1) ? int'(b_hit) : int'(a_hit);
      if (((d == 1) ? b_state : a_state) == IDLE) begin timed_out = 1'b0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_tick(input int d, output int hits_seen, output logic timed_out);
    if (d == 1) b_tick = 1'b1; else tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; b_tick = 1'b0;
    wait_idle(d, hits_seen, timed_out);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (a_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", a_state, IDLE); end
    checks++; if (a_if.spawn_ack !== 1'b0 || a_if.spawn_drop !== 1'b0) begin errors++; $display("FAIL reset_ack_drop got %b%b want 00", a_if.spawn_ack, a_if.spawn_drop); end
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", a_hit); end
    checks++; if (a_hit_count !== 8'd0) begin errors++; $display("FAIL reset_hit_count got %0d want 0", a_hit_count); end
    checks++; if (a_ativos !== 4'd0) begin errors++; $display("FAIL reset_ativos got %0d want 0", a_ativos); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", a_overrun); end
    checks++; if (a_pixel_on !== 1'b0) begin errors++; $display("FAIL reset_pixel_on got %b want 0", a_pixel_on); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL reset_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_spawn_move();
    logic ack, drop, to;
    int s, h;
    do_reset();
    do_spawn(0, 100, 200, ack, drop);
    s = model_spawn(0, 100, 200);
    checks++; if (ack !== (s >= 0) || drop !== (s < 0)) begin errors++; $display("FAIL spawn_first got ack=%b drop=%b want slot %0d", ack, drop, s); end
    @(negedge clk);
    checks++; if (int'(a_ativos) !== model_count(0)) begin errors++; $display("FAIL spawn_ativos got %0d want %0d", a_ativos, model_count(0)); end
    @(posedge clk); #1;
    do_tick(0, h, to);
    model_tick(0, t_ax, t_ay, t_aw, t_ah);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL move_timeout got %b want 0", to); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL move_slots got %h want %h", live_only(a_slots), model_slots(0)); end
  endtask

  task automatic test_fill();
    int cx, cy, s, events, acks, drop_at;
    logic got;
    do_reset();
    events = 0; acks = 0; drop_at = 0;
    cx = $urandom_range(0, 639); cy = $urandom_range(100, 479);
    a_if.spawn_x = CW'(cx); a_if.spawn_y = CW'(cy); a_if.spawn_req = 1'b1;
    for (int c = 0; c < 80 && events < 9; c++) begin
      @(negedge clk);
      got = a_if.spawn_ack | a_if.spawn_drop;
      if (got) begin
        s = model_spawn(0, cx, cy);
        events++;
        checks++; if (a_if.spawn_ack !== (s >= 0)) begin errors++; $display("FAIL fill_event%0d got ack=%b want %b", events, a_if.spawn_ack, s >= 0); end
        if (a_if.spawn_ack) acks++;
        if (a_if.spawn_drop) drop_at = events;
      end
      @(posedge clk); #1;
      if (got) begin
        cx = $urandom_range(0, 639); cy = $urandom_range(100, 479);
        a_if.spawn_x = CW'(cx); a_if.spawn_y = CW'(cy);
      end
    end
    a_if.spawn_req = 1'b0;
    checks++; if (acks !== 8) begin errors++; $display("FAIL fill_acks got %0d want 8", acks); end
    checks++; if (drop_at !== 9) begin errors++; $display("FAIL fill_drop_position got %0d want 9", drop_at); end
    @(negedge clk);
    checks++; if (int'(a_ativos) !== model_count(0)) begin errors++; $display("FAIL fill_ativos got %0d want %0d", a_ativos, model_count(0)); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL fill_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_offscreen_up();
    logic ack, drop, to;
    int h;
    do_reset();
    do_spawn(0, 50, 3, ack, drop);   void'(model_spawn(0, 50, 3));
    do_spawn(0, 60, 100, ack, drop); void'(model_spawn(0, 60, 100));
    do_spawn(0, 70, 4, ack, drop);   void'(model_spawn(0, 70, 4));
    do_tick(0, h, to);
    model_tick(0, t_ax, t_ay, t_aw, t_ah);
    checks++; if (h !== 0) begin errors++; $display("FAIL up_edge_hits got %0d want 0", h); end
    checks++; if (int'(a_ativos) !== model_count(0)) begin errors++; $display("FAIL up_edge_ativos got %0d want %0d", a_ativos, model_count(0)); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL up_edge_slots got %h want %h", live_only(a_slots), model_slots(0)); end
  endtask

  task automatic test_offscreen_down();
    logic ack, drop, to;
    int h;
    do_reset();
    do_spawn(1, 50, 477, ack, drop); void'(model_spawn(1, 50, 477));
    do_spawn(1, 60, 475, ack, drop); void'(model_spawn(1, 60, 475));
    do_spawn(1, 70, 476, ack, drop); void'(model_spawn(1, 70, 476));
    do_tick(1, h, to);
    model_tick(1, 0, 0, 0, 0);
    checks++; if (to !== 1'b0 || h !== 0) begin errors++; $display("FAIL down_edge_pass got timeout=%b hits=%0d want 0 0", to, h); end
    checks++; if (int'(b_ativos) !== model_count(1)) begin errors++; $display("FAIL down_edge_ativos got %0d want %0d", b_ativos, model_count(1)); end
    checks++; if (live_only(b_slots) !== model_slots(1)) begin errors++; $display("FAIL down_edge_slots got %h want %h", live_only(b_slots), model_slots(1)); end
  endtask

  task automatic test_hit();
    logic ack, drop, to;
    int h;
    do_reset();
    set_target(90, 180, 20, 10);
    do_spawn(0, 100, 194, ack, drop); void'(model_spawn(0, 100, 194));
    do_spawn(0, 100, 193, ack, drop); void'(model_spawn(0, 100, 193));
    do_spawn(0, 110, 190, ack, drop); void'(model_spawn(0, 110, 190));
    do_spawn(0, 90, 190, ack, drop);  void'(model_spawn(0, 90, 190));
    do_tick(0, h, to);
    model_tick(0, t_ax, t_ay, t_aw, t_ah);
    checks++; if (h !== m_hits[0]) begin errors++; $display("FAIL hit_pulses got %0d want %0d", h, m_hits[0]); end
    checks++; if (int'(a_hit_count) !== (m_hits[0] & 255)) begin errors++; $display("FAIL hit_count got %0d want %0d", a_hit_count, m_hits[0] & 255); end
    checks++; if (int'(a_ativos) !== model_count(0)) begin errors++; $display("FAIL hit_ativos got %0d want %0d", a_ativos, model_count(0)); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL hit_slots got %h want %h", live_only(a_slots), model_slots(0)); end
  endtask

  task automatic test_pixel();
    logic ack, drop, exp;
    int px[$], py[$];
    do_reset();
    do_spawn(0, 300, 300, ack, drop); void'(model_spawn(0, 300, 300));
    do_spawn(0, 1, 50, ack, drop);    void'(model_spawn(0, 1, 50));
    for (int v = 294; v <= 306; v++) begin px.push_back(v); py.push_back(300); end
    for (int v = 294; v <= 306; v++) begin px.push_back(300); py.push_back(v); end
    px.push_back(303);  py.push_back(303);
    px.push_back(304);  py.push_back(303);
    px.push_back(297);  py.push_back(296);
    px.push_back(1020); py.push_back(50);
    px.push_back(0);    py.push_back(50);
    px.push_back(4);    py.push_back(50);
    px.push_back(5);    py.push_back(50);
    for (int i = 0; i <= px.size(); i++) begin
      if (i < px.size()) begin vga_x = CW'(px[i]); vga_y = CW'(py[i]); end
      if (i > 0) begin
        #1;
        exp = model_pixel(px[i-1], py[i-1]);
        checks++; if (a_pixel_on !== exp) begin errors++; $display("FAIL pixel_at_%0d_%0d got %b want %b", px[i-1], py[i-1], a_pixel_on, exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overrun_pause();
    logic ack, drop, to, got;
    int h, bad;
    do_reset();
    do_spawn(0, 200, 300, ack, drop); void'(model_spawn(0, 200, 300));
    // Two ticks in one pass: the second is held and replayed.
    tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
    wait_idle(0, h, to);
    model_tick(0, t_ax, t_ay, t_aw, t_ah); model_tick(0, t_ax, t_ay, t_aw, t_ah);
    checks++; if (to !== 1'b0 || a_overrun !== 1'b0) begin errors++; $display("FAIL pending_pass got timeout=%b overrun=%b want 0 0", to, a_overrun); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL pending_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    // Three ticks in one pass: the third is lost.
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
      @(posedge clk); #1;
    end
    wait_idle(0, h, to);
    model_tick(0, t_ax, t_ay, t_aw, t_ah); model_tick(0, t_ax, t_ay, t_aw, t_ah);
    checks++; if (to !== 1'b0 || a_overrun !== 1'b1) begin errors++; $display("FAIL overrun_pass got timeout=%b overrun=%b want 0 1", to, a_overrun); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL overrun_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    // Frozen: tick and spawn both ignored until pausa drops.
    pausa = 1'b1; tick = 1'b1;
    a_if.spawn_x = CW'(10); a_if.spawn_y = CW'(100); a_if.spawn_req = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_if.spawn_ack || a_if.spawn_drop || a_state != IDLE) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_freeze got %0d active cycles want 0", bad); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL pause_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    pausa = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_if.spawn_ack) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1; a_if.spawn_req = 1'b0;
    void'(model_spawn(0, 10, 100));
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL unpause_ack got %b want 1", got); end
    @(negedge clk);
    checks++; if (live_only(a_slots) !== model_slots(0) || a_overrun !== 1'b1) begin errors++; $display("FAIL unpause_state got %h ovr=%b want %h ovr=1", live_only(a_slots), a_overrun, model_slots(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_update();
    logic ack, drop;
    do_reset();
    do_spawn(0, 400, 300, ack, drop);
    do_spawn(0, 410, 310, ack, drop);
    tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (a_state !== UPDATE) begin errors++; $display("FAIL midscan_state got %0d want %0d", a_state, UPDATE); end
    do_reset();
    @(negedge clk);
    checks++; if (a_state !== IDLE || a_idx !== 3'd0 || a_ativos !== 4'd0) begin errors++; $display("FAIL midscan_reset got state=%0d idx=%0d ativos=%0d want 0 0 0", a_state, a_idx, a_ativos); end
    checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL midscan_slots got %h want %h", live_only(a_slots), model_slots(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic ack, drop, to;
    int s, h, x, y, nt, hits_before;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      set_target($urandom_range(0, 600), $urandom_range(0, 400), $urandom_range(0, 150), $urandom_range(0, 150));
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        x = $urandom_range(0, 639); y = $urandom_range(0, 479);
        do_spawn(0, x, y, ack, drop);
        s = model_spawn(0, x, y);
        checks++; if (ack !== (s >= 0) || drop !== (s < 0)) begin errors++; $display("FAIL rand_spawn_r%0d got ack=%b drop=%b want slot %0d", r, ack, drop, s); end
      end
      nt = $urandom_range(1, 2);
      for (int k = 0; k < nt; k++) begin
        hits_before = m_hits[0];
        do_tick(0, h, to);
        model_tick(0, t_ax, t_ay, t_aw, t_ah);
        checks++; if (to !== 1'b0 || h !== m_hits[0] - hits_before) begin errors++; $display("FAIL rand_tick_r%0d got timeout=%b hits=%0d want 0 %0d", r, to, h, m_hits[0] - hits_before); end
      end
      checks++; if (int'(a_hit_count) !== (m_hits[0] & 255) || int'(a_ativos) !== model_count(0)) begin errors++; $display("FAIL rand_counts_r%0d got hc=%0d ativos=%0d want %0d %0d", r, a_hit_count, a_ativos, m_hits[0] & 255, model_count(0)); end
      checks++; if (live_only(a_slots) !== model_slots(0)) begin errors++; $display("FAIL rand_slots_r%0d got %h want %h", r, live_only(a_slots), model_slots(0)); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spawn_move();
    test_fill();
    test_offscreen_up();
    test_offscreen_down();
    test_hit();
    test_pixel();
    test_overrun_pause();
    test_reset_mid_update();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
